// File: rtl/cla_multibeat_adder.sv
// ============================================================================
// Module   : cla_multibeat_adder (with carry_lookahead_adder)
// Brief    : Wide adder that sums WIDTH-bit operands one BIT-wide slice per
//            clock through a single carry-lookahead slice adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module carry_lookahead_adder #(
  parameter int BIT = 32
) (
  input  logic [BIT-1:0] i_a,
  input  logic [BIT-1:0] i_b,
  input  logic           i_cin,
  output logic [BIT-1:0] o_sum,
  output logic           o_cout
);
  logic [BIT-1:0] w_g;
  logic [BIT-1:0] w_p;
  logic [BIT:0]   w_c;
  logic           w_acc;
  logic           w_pp;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  // Each carry is formed directly from generate/propagate terms, not rippled.
  always_comb begin
    w_c    = '0;
    w_c[0] = i_cin;
    w_acc  = 1'b0;
    w_pp   = 1'b0;
    for (int i = 0; i < BIT; i++) begin
      w_acc = w_g[i];
      w_pp  = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc = w_acc | (w_pp & w_g[j]);
        w_pp  = w_pp & w_p[j];
      end
      w_acc      = w_acc | (w_pp & i_cin);
      w_c[i + 1] = w_acc;
    end
  end

  assign o_sum  = w_p ^ w_c[BIT-1:0];
  assign o_cout = w_c[BIT];
endmodule

module cla_multibeat_adder #(
  parameter int WIDTH = 128,
  parameter int BIT   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data_s,
  output logic             o_carry
);
  localparam int NBEAT = WIDTH / BIT;
  localparam int CNT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEAT - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [BIT-1:0]   w_cla_a;
  logic [BIT-1:0]   w_cla_b;
  logic [BIT-1:0]   w_cla_sum;
  logic             w_cla_cout;

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_valid)              state_d = S_CALC;
      S_CALC:  if (cnt_q == LAST_BEAT)   state_d = S_DONE;
      S_DONE:  if (i_ready)              state_d = S_IDLE;
      default:                           state_d = S_IDLE;
    endcase
  end

  // Outputs decode from state and registers only
  always_comb begin
    o_ready  = (state_q == S_IDLE);
    o_valid  = (state_q == S_DONE);
    o_data_s = sum_q;
    o_carry  = cout_q;
  end

  always_comb begin
    w_cla_a = '0;
    w_cla_b = '0;
    for (int k = 0; k < NBEAT; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        w_cla_a = a_q[k*BIT +: BIT];
        w_cla_b = b_q[k*BIT +: BIT];
      end
    end
  end

  carry_lookahead_adder #(
    .BIT (BIT)
  ) u_cla (
    .i_a    (w_cla_a),
    .i_b    (w_cla_b),
    .i_cin  (carry_q),
    .o_sum  (w_cla_sum),
    .o_cout (w_cla_cout)
  );

  always_comb begin
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          a_d     = i_data_a;
          b_d     = i_data_b;
          carry_d = i_carry;
          cnt_d   = '0;
        end
      end
      S_CALC: begin
        for (int k = 0; k < NBEAT; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*BIT +: BIT] = w_cla_sum;
        end
        carry_d = w_cla_cout;
        // The counter parks on the last beat instead of wrapping.
        if (cnt_q == LAST_BEAT) cout_d = w_cla_cout;
        else                    cnt_d  = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_cla_multibeat_adder.sv
// ============================================================================
// Module   : tb_cla_multibeat_adder
// Brief    : Bench for the multibeat adder in 128/32 and 32/32 configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_multibeat_adder;
  localparam int W  = 128;
  localparam int WN = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic         valid = 1'b0, rdy_in = 1'b0, cin = 1'b0;
  logic         ready_o, vout, cout;
  logic [W-1:0] a = '0, b = '0, s;

  logic          n_valid = 1'b0, n_rdy_in = 1'b0, n_cin = 1'b0;
  logic          n_ready_o, n_vout, n_cout;
  logic [WN-1:0] n_a = '0, n_b = '0, n_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_multibeat_adder #(.WIDTH(W), .BIT(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready_o),
    .i_data_a(a), .i_data_b(b), .i_carry(cin), .o_valid(vout),
    .i_ready(rdy_in), .o_data_s(s), .o_carry(cout)
  );

  cla_multibeat_adder #(.WIDTH(WN), .BIT(32)) u_dut_n (
    .i_clk(clk), .i_rst(rst), .i_valid(n_valid), .o_ready(n_ready_o),
    .i_data_a(n_a), .i_data_b(n_b), .i_carry(n_cin), .o_valid(n_vout),
    .i_ready(n_rdy_in), .o_data_s(n_s), .o_carry(n_cout)
  );

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic [WN:0] ref_addn(input logic [WN-1:0] x, input logic [WN-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{WN{1'b0}}, c};
  endfunction

  function automatic logic [W-1:0] rnd_w();
    logic [W-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      default: ;
    endcase
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete add on the wide DUT; returns result, cycles to o_valid, and whether o_ready stayed low.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        output logic [W:0] res, output int lat, output bit rdy_low);
    a = x; b = y; cin = c; valid = 1'b1; rdy_in = 1'b0;
    tick();
    valid = 1'b0;
    lat = 0;
    rdy_low = 1'b1;
    while (!vout && lat < 20) begin
      if (ready_o) rdy_low = 1'b0;
      tick();
      lat++;
    end
    res = {cout, s};
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (ready_o !== 1'b1 || vout !== 1'b0 || s !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_wide: got rdy=%b vld=%b s=%h c=%b required rdy=1 vld=0 s=0 c=0", ready_o, vout, s, cout);
    end
    n_cmp++;
    if (n_ready_o !== 1'b1 || n_vout !== 1'b0 || n_s !== '0 || n_cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_narrow: got rdy=%b vld=%b s=%h c=%b required rdy=1 vld=0 s=0 c=0", n_ready_o, n_vout, n_s, n_cout);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_carry_chain();
    logic [W:0] res;
    int lat;
    bit rl;
    do_add('1, 128'd1, 1'b0, res, lat, rl);
    n_cmp++;
    if (res !== {1'b1, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL carry_chain_sum: got %h required %h", res, {1'b1, {W{1'b0}}});
    end
    n_cmp++;
    if (lat !== 4) begin
      n_err++;
      $display("FAIL carry_chain_latency: got %0d required 4", lat);
    end
    n_cmp++;
    if (rl !== 1'b1) begin
      n_err++;
      $display("FAIL carry_chain_ready_low: got %b required 1", rl);
    end
  endtask

  task automatic test_slice_boundary();
    logic [W:0] res;
    int lat;
    bit rl;
    do_add('0, '0, 1'b1, res, lat, rl);
    n_cmp++;
    if (res !== {1'b0, 128'h1}) begin
      n_err++;
      $display("FAIL cin_only: got %h required %h", res, {1'b0, 128'h1});
    end
    do_add(128'hFFFF_FFFF, 128'd1, 1'b0, res, lat, rl);
    n_cmp++;
    if (res !== {1'b0, 128'h1_0000_0000}) begin
      n_err++;
      $display("FAIL slice_cross: got %h required %h", res, {1'b0, 128'h1_0000_0000});
    end
    do_add(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'hF0F0_F0F0_0F0F_0F0F_FFFF_0000_0000_FFFF,
           1'b1, res, lat, rl);
    n_cmp++;
    if (res !== ref_add(128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                        128'hF0F0_F0F0_0F0F_0F0F_FFFF_0000_0000_FFFF, 1'b1)) begin
      n_err++;
      $display("FAIL mixed_pattern: got %h", res);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] x1, y1, x2, y2;
    logic [W:0]   exp1, res;
    int lat;
    x1 = 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_1234_5678;
    y1 = 128'h1111_2222_3333_4444_0000_0001_8765_4321;
    x2 = 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
    y2 = 128'h0000_0000_0000_0000_0000_0000_0000_0003;
    exp1 = ref_add(x1, y1, 1'b0);
    a = x1; b = y1; cin = 1'b0; valid = 1'b1; rdy_in = 1'b0;
    tick();
    a = x2; b = y2; cin = 1'b1;
    lat = 0;
    while (!vout && lat < 20) begin
      tick();
      lat++;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (vout !== 1'b1 || {cout, s} !== exp1 || ready_o !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                 i, vout, ready_o, {cout, s}, exp1);
      end
      tick();
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
    n_cmp++;
    if (vout !== 1'b0 || ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL backpressure_release: got vld=%b rdy=%b required vld=0 rdy=1", vout, ready_o);
    end
    tick();
    valid = 1'b0;
    n_cmp++;
    if (ready_o !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_accept: got rdy=%b required 0", ready_o);
    end
    lat = 0;
    while (!vout && lat < 20) begin
      tick();
      lat++;
    end
    res = {cout, s};
    n_cmp++;
    if (res !== ref_add(x2, y2, 1'b1) || lat !== 4) begin
      n_err++;
      $display("FAIL backpressure_second: got res=%h lat=%0d required res=%h lat=4", res, lat, ref_add(x2, y2, 1'b1));
    end
    rdy_in = 1'b1;
    tick();
    rdy_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [W:0] res;
    int lat;
    bit rl;
    a = {1'b1, 127'b0}; b = {1'b1, 127'b0}; cin = 1'b0; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (vout !== 1'b0 || ready_o !== 1'b1 || s !== '0 || cout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got vld=%b rdy=%b s=%h c=%b required vld=0 rdy=1 s=0 c=0", vout, ready_o, s, cout);
    end
    tick();
    rst = 1'b0;
    tick();
    do_add(128'd5, 128'd7, 1'b1, res, lat, rl);
    n_cmp++;
    if (res !== {1'b0, 128'd13} || lat !== 4) begin
      n_err++;
      $display("FAIL after_reset_add: got res=%h lat=%0d required res=%h lat=4", res, lat, {1'b0, 128'd13});
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] expq[$];
    logic [W:0] exp;
    int got, cyc, last;
    bit acc;
    got = 0; cyc = 0; last = -1;
    a = rnd_w(); b = rnd_w(); cin = 1'($urandom_range(0, 1));
    valid = 1'b1; rdy_in = 1'b1;
    while (got < 1000 && cyc < 7000) begin
      if (vout) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 'x;
        n_cmp++;
        if ({cout, s} !== exp || (last >= 0 && cyc - last != 6)) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: got %h period %0d required %h period 6", got, {cout, s}, cyc - last, exp);
        end
        last = cyc;
        got++;
      end
      acc = ready_o;
      if (acc) expq.push_back(ref_add(a, b, cin));
      tick();
      cyc++;
      if (acc) begin
        a = rnd_w(); b = rnd_w(); cin = 1'($urandom_range(0, 1));
      end
    end
    n_cmp++;
    if (got != 1000) begin
      n_err++;
      $display("FAIL back_to_back_count: got %0d results required 1000", got);
    end
    valid = 1'b0;
    tick();
    rdy_in = 1'b0;
    tick();
  endtask

  task automatic test_narrow();
    logic [WN:0] expq[$];
    logic [WN:0] exp;
    int lat, got, cyc, last;
    bit acc;
    n_a = '1; n_b = '1; n_cin = 1'b1; n_valid = 1'b1; n_rdy_in = 1'b0;
    tick();
    n_valid = 1'b0;
    lat = 0;
    while (!n_vout && lat < 20) begin
      tick();
      lat++;
    end
    n_cmp++;
    if ({n_cout, n_s} !== {1'b1, 32'hFFFF_FFFF} || lat !== 1) begin
      n_err++;
      $display("FAIL narrow_max: got res=%h lat=%0d required res=%h lat=1", {n_cout, n_s}, lat, {1'b1, 32'hFFFF_FFFF});
    end
    n_rdy_in = 1'b1;
    tick();
    got = 0; cyc = 0; last = -1;
    n_a = $urandom(); n_b = $urandom(); n_cin = 1'($urandom_range(0, 1));
    n_valid = 1'b1;
    while (got < 200 && cyc < 1000) begin
      if (n_vout) begin
        exp = (expq.size() > 0) ? expq.pop_front() : 'x;
        n_cmp++;
        if ({n_cout, n_s} !== exp || (last >= 0 && cyc - last != 3)) begin
          n_err++;
          $display("FAIL narrow_random[%0d]: got %h period %0d required %h period 3", got, {n_cout, n_s}, cyc - last, exp);
        end
        last = cyc;
        got++;
      end
      acc = n_ready_o;
      if (acc) expq.push_back(ref_addn(n_a, n_b, n_cin));
      tick();
      cyc++;
      if (acc) begin
        n_a = $urandom(); n_b = $urandom(); n_cin = 1'($urandom_range(0, 1));
      end
    end
    n_cmp++;
    if (got != 200) begin
      n_err++;
      $display("FAIL narrow_count: got %0d results required 200", got);
    end
    n_valid = 1'b0;
    n_rdy_in = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_carry_chain();
    test_slice_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
